// File: rtl/rr_mux_arbiter4.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : rr_mux_arbiter4
// Brief   : Four-way round-robin burst arbiter feeding a valid/ready output port.
// Revision: 1.0
//------------------------------------------------------------------------------
module rr_mux_arbiter4 #(
    parameter int DW        = 8,
    parameter int MAX_BEATS = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      req,
    input  logic [4*DW-1:0] in_data,
    input  logic            out_ready,
    output logic [3:0]      gnt,
    output logic [1:0]      sel,
    output logic            out_valid,
    output logic [DW-1:0]   out_data,
    output logic [3:0]      ack
);

    localparam int CW = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CW-1:0] C_LAST_BEAT = CW'(MAX_BEATS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [3:0]    r_gnt, w_gnt_nxt;
    logic [1:0]    r_sel, w_sel_nxt;
    logic [1:0]    r_last, w_last_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;

    logic [1:0]    w_shift;
    logic [3:0]    w_rot;
    logic [1:0]    w_off;
    logic [1:0]    w_winner;
    logic          w_busy;
    logic          w_accept;

    // Rotate requests so the slot after the last winner sits at bit 0.
    assign w_shift = r_last + 2'd1;

    always_comb begin
        w_rot = '0;
        for (int k = 0; k < 4; k++) begin
            w_rot[k] = req[w_shift + 2'(k)];
        end
    end

    always_comb begin
        casez (w_rot)
            4'b???1: w_off = 2'd0;
            4'b??10: w_off = 2'd1;
            4'b?100: w_off = 2'd2;
            4'b1000: w_off = 2'd3;
            default: w_off = 2'd0;
        endcase
    end

    assign w_winner  = w_shift + w_off;
    assign w_busy    = (r_state == ST_BUSY);
    assign out_valid = w_busy && req[r_sel];
    assign w_accept  = out_valid && out_ready;
    assign out_data  = in_data[int'(r_sel)*DW +: DW];
    // A beat presented in a reset cycle is discarded, so it is never acknowledged.
    assign ack       = (w_accept && !rst) ? (4'b0001 << r_sel) : 4'b0000;
    assign gnt       = r_gnt;
    assign sel       = r_sel;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_sel_nxt   = r_sel;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (req != 4'b0000) begin
                    w_state_nxt = ST_BUSY;
                    w_sel_nxt   = w_winner;
                    w_gnt_nxt   = 4'b0001 << w_winner;
                    w_cnt_nxt   = '0;
                end
            end
            ST_BUSY: begin
                if (!req[r_sel] || (w_accept && (r_cnt == C_LAST_BEAT))) begin
                    w_state_nxt = ST_IDLE;
                    w_last_nxt  = r_sel;
                    w_gnt_nxt   = 4'b0000;
                    w_cnt_nxt   = '0;
                end else if (w_accept) begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_gnt   <= 4'b0000;
            r_sel   <= 2'd0;
            r_last  <= 2'd3;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_sel   <= w_sel_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_mux_arbiter4.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_rr_mux_arbiter4
// Brief   : Directed self-checking bench for rr_mux_arbiter4 (DW=8, MAX_BEATS=4).
// Revision: 1.0
//------------------------------------------------------------------------------
module tb_rr_mux_arbiter4;

    localparam int DW = 8;

    logic          clk;
    logic          rst;
    logic [3:0]    req;
    logic [4*DW-1:0] in_data;
    logic          out_ready;
    logic [3:0]    gnt;
    logic [1:0]    sel;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [3:0]    ack;

    int total = 0;
    int bad   = 0;

    rr_mux_arbiter4 #(.DW(DW), .MAX_BEATS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .in_data   (in_data),
        .out_ready (out_ready),
        .gnt       (gnt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .ack       (ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;
        step();
        rst       = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            total++;
            if ({gnt, sel, out_valid, ack} !== 11'b0) begin
                bad++;
                $display("FAIL reset_outputs cycle=%0d gnt=%b sel=%0d out_valid=%b ack=%b expected all zero",
                         c, gnt, sel, out_valid, ack);
            end
            step();
        end
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL reset_idle_after_release gnt=%b expected 0000", gnt);
        end
        step();
        @(negedge clk);
        total++;
        if ({gnt, sel} !== {4'b0001, 2'd0}) begin
            bad++;
            $display("FAIL reset_first_grant gnt=%b sel=%0d expected 0001 sel=0", gnt, sel);
        end
        do_reset();
    endtask

    task automatic test_single_burst();
        req       = 4'b0010;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({gnt, ack} !== 8'b0) begin
            bad++;
            $display("FAIL single_latency gnt=%b ack=%b expected 0000/0000", gnt, ack);
        end
        step();
        for (int b = 0; b < 4; b++) begin
            @(negedge clk);
            total++;
            if ({gnt, ack, sel} !== {4'b0010, 4'b0010, 2'd1}) begin
                bad++;
                $display("FAIL single_beat b=%0d gnt=%b ack=%b sel=%0d expected 0010/0010/1",
                         b, gnt, ack, sel);
            end
            step();
        end
        @(negedge clk);
        total++;
        if ({gnt, out_valid, ack} !== 9'b0) begin
            bad++;
            $display("FAIL single_gap gnt=%b out_valid=%b ack=%b expected 0", gnt, out_valid, ack);
        end
        step();
        @(negedge clk);
        total++;
        if (gnt !== 4'b0010) begin
            bad++;
            $display("FAIL single_regrant gnt=%b expected 0010", gnt);
        end
        do_reset();
    endtask

    task automatic test_round_robin();
        logic [3:0] e;
        req       = 4'b1111;
        out_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            e = 4'b0001 << (g % 4);
            @(negedge clk);
            total++;
            if ({gnt, out_valid} !== 5'b0) begin
                bad++;
                $display("FAIL rr_gap g=%0d gnt=%b out_valid=%b expected 0000/0", g, gnt, out_valid);
            end
            step();
            for (int b = 0; b < 4; b++) begin
                @(negedge clk);
                total++;
                if ({gnt, ack, sel} !== {e, e, 2'(g % 4)}) begin
                    bad++;
                    $display("FAIL rr_beat g=%0d b=%0d gnt=%b ack=%b sel=%0d expected %b/%b/%0d",
                             g, b, gnt, ack, sel, e, e, g % 4);
                end
                step();
            end
        end
        do_reset();
    endtask

    task automatic test_backpressure();
        in_data   = {8'hD3, 8'hC2, 8'hB1, 8'hA0};
        req       = 4'b0100;
        out_ready = 1'b1;
        step();
        @(negedge clk);
        total++;
        if ({gnt, ack, out_data} !== {4'b0100, 4'b0100, 8'hC2}) begin
            bad++;
            $display("FAIL bp_first_beat gnt=%b ack=%b data=%h expected 0100/0100/c2", gnt, ack, out_data);
        end
        step();
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (s == 1) in_data[23:16] = 8'h5A;
            @(negedge clk);
            total++;
            if ({gnt, ack, out_valid, out_data} !== {4'b0100, 4'b0000, 1'b1, (s >= 1) ? 8'h5A : 8'hC2}) begin
                bad++;
                $display("FAIL bp_stall s=%0d gnt=%b ack=%b out_valid=%b data=%h", s, gnt, ack, out_valid, out_data);
            end
            step();
        end
        out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            total++;
            if ({gnt, ack} !== {4'b0100, 4'b0100}) begin
                bad++;
                $display("FAIL bp_resume b=%0d gnt=%b ack=%b expected 0100/0100", b, gnt, ack);
            end
            step();
        end
        @(negedge clk);
        total++;
        if ({gnt, ack} !== 8'b0) begin
            bad++;
            $display("FAIL bp_release gnt=%b ack=%b expected 0000/0000", gnt, ack);
        end
        do_reset();
    endtask

    task automatic test_withdraw();
        req       = 4'b0100;
        out_ready = 1'b1;
        step();
        for (int b = 0; b < 2; b++) begin
            @(negedge clk);
            total++;
            if (ack !== 4'b0100) begin
                bad++;
                $display("FAIL wd_beat b=%0d ack=%b expected 0100", b, ack);
            end
            step();
        end
        req = 4'b1000;
        @(negedge clk);
        total++;
        if ({gnt, out_valid, ack} !== {4'b0100, 1'b0, 4'b0000}) begin
            bad++;
            $display("FAIL wd_drop gnt=%b out_valid=%b ack=%b expected 0100/0/0000", gnt, out_valid, ack);
        end
        step();
        @(negedge clk);
        total++;
        if (gnt !== 4'b0000) begin
            bad++;
            $display("FAIL wd_release gnt=%b expected 0000", gnt);
        end
        step();
        @(negedge clk);
        total++;
        if ({gnt, sel} !== {4'b1000, 2'd3}) begin
            bad++;
            $display("FAIL wd_next_grant gnt=%b sel=%0d expected 1000/3", gnt, sel);
        end
        do_reset();
    endtask

    task automatic test_reset_busy();
        // A completed burst of requester 0 moves the pointer away from its reset value first.
        req       = 4'b0001;
        out_ready = 1'b1;
        step();
        for (int b = 0; b < 4; b++) step();
        req = 4'b0010;
        step();
        @(negedge clk);
        total++;
        if ({gnt, ack} !== {4'b0010, 4'b0010}) begin
            bad++;
            $display("FAIL rb_beat gnt=%b ack=%b expected 0010/0010", gnt, ack);
        end
        step();
        rst = 1'b1;
        @(negedge clk);
        total++;
        if (ack !== 4'b0000) begin
            bad++;
            $display("FAIL rb_ack_in_reset ack=%b expected 0000", ack);
        end
        step();
        rst = 1'b0;
        req = 4'b0011;
        @(negedge clk);
        total++;
        if ({gnt, out_valid} !== 5'b0) begin
            bad++;
            $display("FAIL rb_idle gnt=%b out_valid=%b expected 0000/0", gnt, out_valid);
        end
        step();
        @(negedge clk);
        total++;
        if (gnt !== 4'b0001) begin
            bad++;
            $display("FAIL rb_next_grant gnt=%b expected 0001", gnt);
        end
        do_reset();
    endtask

    initial begin
        rst       = 1'b1;
        req       = 4'b0000;
        out_ready = 1'b0;
        in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
        #1;
        test_reset();
        test_single_burst();
        test_round_robin();
        test_backpressure();
        test_withdraw();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
